// File: rtl/id_ex_operand_stage_if.sv
// ID/EX operand stage bundle: hazard controls, ID operands, MEM/WB forward sources and EX outputs.
// master = surrounding pipeline (drives ID/hazard/forward inputs), slave = the stage itself.
interface id_ex_operand_stage_if #(
   parameter int XLEN   = 32,
   parameter int REG_AW = 5
);
   logic              stall;
   logic              flush;
   logic              id_valid;
   logic [XLEN-1:0]   id_rs1_data;
   logic [XLEN-1:0]   id_rs2_data;
   logic [XLEN-1:0]   id_imm;
   logic [REG_AW-1:0] id_rs1;
   logic [REG_AW-1:0] id_rs2;
   logic [REG_AW-1:0] id_rd;
   logic              id_alu_src;
   logic [2:0]        id_alu_ctrl;
   logic              id_reg_write;
   logic [REG_AW-1:0] mem_rd;
   logic              mem_reg_write;
   logic [XLEN-1:0]   mem_result;
   logic [REG_AW-1:0] wb_rd;
   logic              wb_reg_write;
   logic [XLEN-1:0]   wb_result;
   logic              ex_valid;
   logic [XLEN-1:0]   alu_a;
   logic [XLEN-1:0]   alu_b;
   logic [2:0]        alu_ctrl;
   logic [XLEN-1:0]   ex_store_data;
   logic [REG_AW-1:0] ex_rd;
   logic              ex_reg_write;

   modport master (
      output stall, flush, id_valid, id_rs1_data, id_rs2_data, id_imm,
             id_rs1, id_rs2, id_rd, id_alu_src, id_alu_ctrl, id_reg_write,
             mem_rd, mem_reg_write, mem_result, wb_rd, wb_reg_write, wb_result,
      input  ex_valid, alu_a, alu_b, alu_ctrl, ex_store_data, ex_rd, ex_reg_write
   );

   modport slave (
      input  stall, flush, id_valid, id_rs1_data, id_rs2_data, id_imm,
             id_rs1, id_rs2, id_rd, id_alu_src, id_alu_ctrl, id_reg_write,
             mem_rd, mem_reg_write, mem_result, wb_rd, wb_reg_write, wb_result,
      output ex_valid, alu_a, alu_b, alu_ctrl, ex_store_data, ex_rd, ex_reg_write
   );
endinterface

// File: rtl/id_ex_operand_stage.sv
// ID/EX register + EX operand forwarding (MEM beats WB, rd 0 never forwards); 1-cycle latency,
// stall holds / flush bubbles, no other backpressure. Forwarding only when EX_FORWARD_EN is defined.
module id_ex_operand_stage #(
   parameter int XLEN   = 32,
   parameter int REG_AW = 5
) (
   input logic                  clk,
   input logic                  rst,
   id_ex_operand_stage_if.slave bus
);
   logic              vld_q;
   logic [XLEN-1:0]   rs1_data_q;
   logic [XLEN-1:0]   rs2_data_q;
   logic [XLEN-1:0]   imm_q;
   logic [REG_AW-1:0] rs1_q;
   logic [REG_AW-1:0] rs2_q;
   logic [REG_AW-1:0] rd_q;
   logic              alu_src_q;
   logic [2:0]        alu_ctrl_q;
   logic              reg_write_q;

   always_ff @(posedge clk) begin
      if (rst || bus.flush) begin
         vld_q       <= 1'b0;
         rs1_data_q  <= '0;
         rs2_data_q  <= '0;
         imm_q       <= '0;
         rs1_q       <= '0;
         rs2_q       <= '0;
         rd_q        <= '0;
         alu_src_q   <= 1'b0;
         alu_ctrl_q  <= 3'b000;
         reg_write_q <= 1'b0;
      end else if (!bus.stall) begin
         vld_q       <= bus.id_valid;
         rs1_data_q  <= bus.id_rs1_data;
         rs2_data_q  <= bus.id_rs2_data;
         imm_q       <= bus.id_imm;
         rs1_q       <= bus.id_rs1;
         rs2_q       <= bus.id_rs2;
         rd_q        <= bus.id_rd;
         alu_src_q   <= bus.id_alu_src;
         alu_ctrl_q  <= bus.id_alu_ctrl;
         reg_write_q <= bus.id_reg_write & bus.id_valid;
      end
   end

   logic [XLEN-1:0] fwd_rs1;
   logic [XLEN-1:0] fwd_rs2;

`ifdef EX_FORWARD_EN
   logic mem_hit1, mem_hit2, wb_hit1, wb_hit2;

   always_comb begin
      mem_hit1 = bus.mem_reg_write && (bus.mem_rd != '0) && (bus.mem_rd == rs1_q);
      mem_hit2 = bus.mem_reg_write && (bus.mem_rd != '0) && (bus.mem_rd == rs2_q);
      wb_hit1  = bus.wb_reg_write  && (bus.wb_rd  != '0) && (bus.wb_rd  == rs1_q);
      wb_hit2  = bus.wb_reg_write  && (bus.wb_rd  != '0) && (bus.wb_rd  == rs2_q);

      fwd_rs1 = rs1_data_q;
      if (mem_hit1)     fwd_rs1 = bus.mem_result;
      else if (wb_hit1) fwd_rs1 = bus.wb_result;

      fwd_rs2 = rs2_data_q;
      if (mem_hit2)     fwd_rs2 = bus.mem_result;
      else if (wb_hit2) fwd_rs2 = bus.wb_result;
   end
`else
   // Without forwarding the hazard unit stalls every RAW hazard, so these are dead inputs.
   logic unused_fwd_srcs;
   assign unused_fwd_srcs = ^{rs1_q, rs2_q, bus.mem_rd, bus.mem_reg_write, bus.mem_result,
                              bus.wb_rd, bus.wb_reg_write, bus.wb_result};

   always_comb begin
      fwd_rs1 = rs1_data_q;
      fwd_rs2 = rs2_data_q;
   end
`endif

   assign bus.ex_valid      = vld_q;
   assign bus.alu_a         = fwd_rs1;
   assign bus.alu_b         = alu_src_q ? imm_q : fwd_rs2;
   assign bus.alu_ctrl      = alu_ctrl_q;
   assign bus.ex_store_data = fwd_rs2;
   assign bus.ex_rd         = rd_q;
   assign bus.ex_reg_write  = reg_write_q & vld_q;
endmodule
